// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage register: legal DEPTH range,
// performance counter width/saturation value and the slot operation encoding.
package pipe_pkg;

   localparam int unsigned DEPTH_MIN = 1;
   localparam int unsigned DEPTH_MAX = 4;

   localparam int unsigned      CNT_W   = 32;
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   typedef enum logic [1:0] {
      SLOT_HOLD,
      SLOT_LOAD,
      SLOT_CLEAR
   } slot_op_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot: valid bit, payload and control vector with load/hold/clear.
// Clear kills the slot but keeps the payload; control is zeroed for any bubble.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned PAYLOAD_W = 160,
   parameter int unsigned CTRL_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  slot_op_e             op,
   input  logic                 src_valid,
   input  logic [PAYLOAD_W-1:0] src_payload,
   input  logic [CTRL_W-1:0]    src_ctrl,
   output logic                 valid,
   output logic [PAYLOAD_W-1:0] payload,
   output logic [CTRL_W-1:0]    ctrl
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid   <= 1'b0;
         payload <= '0;
         ctrl    <= '0;
      end else begin
         case (op)
            SLOT_LOAD: begin
               valid   <= src_valid;
               payload <= src_payload;
               ctrl    <= src_valid ? src_ctrl : '0;
            end
            SLOT_CLEAR: begin
               valid <= 1'b0;
               ctrl  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-slot inter-stage pipeline register with stall, flush and bubble squeezing.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble performance counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned PAYLOAD_W = 160,
   parameter int unsigned CTRL_W    = 16,
   parameter int unsigned DEPTH     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   input  logic [PAYLOAD_W-1:0] i_payload,
   input  logic [CTRL_W-1:0]    i_ctrl,
   input  logic                 i_stall,
   input  logic                 i_flush,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [PAYLOAD_W-1:0] o_payload,
   output logic [CTRL_W-1:0]    o_ctrl
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]     o_stall_cnt,
   output logic [CNT_W-1:0]     o_bubble_cnt
`endif
);

   logic [DEPTH-1:0]     valid;
   logic [DEPTH-1:0]     adv;
   logic [PAYLOAD_W-1:0] payload [DEPTH];
   logic [CTRL_W-1:0]    ctrl    [DEPTH];
   slot_op_e             op      [DEPTH];

   // Closed form of the ripple chain: slot k advances when the output is
   // consumed or any slot from k to the output side is empty.
   always_comb begin
      logic any_empty;
      adv = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         any_empty = 1'b0;
         for (int unsigned j = k; j < DEPTH; j++) begin
            any_empty = any_empty | !valid[j];
         end
         adv[k] = !i_stall || any_empty;
      end
   end

   for (genvar k = 0; k < int'(DEPTH); k++) begin : g_slot
      logic                 src_valid;
      logic [PAYLOAD_W-1:0] src_payload;
      logic [CTRL_W-1:0]    src_ctrl;

      if (k == 0) begin : g_in
         assign src_valid   = i_valid;
         assign src_payload = i_payload;
         assign src_ctrl    = i_ctrl;
      end else begin : g_chain
         assign src_valid   = valid[k-1];
         assign src_payload = payload[k-1];
         assign src_ctrl    = ctrl[k-1];
      end

      assign op[k] = i_flush ? SLOT_CLEAR : (adv[k] ? SLOT_LOAD : SLOT_HOLD);

      pipe_slot #(
         .PAYLOAD_W (PAYLOAD_W),
         .CTRL_W    (CTRL_W)
      ) u_slot (
         .clk         (clk),
         .rst         (rst),
         .op          (op[k]),
         .src_valid   (src_valid),
         .src_payload (src_payload),
         .src_ctrl    (src_ctrl),
         .valid       (valid[k]),
         .payload     (payload[k]),
         .ctrl        (ctrl[k])
      );
   end

   assign o_ready   = adv[0];
   assign o_valid   = valid[DEPTH-1];
   assign o_payload = payload[DEPTH-1];
   assign o_ctrl    = ctrl[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (o_valid && i_stall) stall_cnt <= sat_inc(stall_cnt);
         if (!o_valid)           bubble_cnt <= sat_inc(bubble_cnt);
      end
   end

   assign o_stall_cnt  = stall_cnt;
   assign o_bubble_cnt = bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (DEPTH = 3): position-based reference model plus an
// in-order scoreboard popped by an independent output monitor.
module tb_pipe_stage_reg;

   localparam int PW = 160;
   localparam int CW = 16;
   localparam int D  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_valid = 1'b0;
   logic [PW-1:0] i_payload = '0;
   logic [CW-1:0] i_ctrl = '0;
   logic          i_stall = 1'b0;
   logic          i_flush = 1'b0;
   logic          o_ready;
   logic          o_valid;
   logic [PW-1:0] o_payload;
   logic [CW-1:0] o_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   o_stall_cnt;
   logic [31:0]   o_bubble_cnt;
`endif

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .PAYLOAD_W (PW),
      .CTRL_W    (CW),
      .DEPTH     (D)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .i_payload    (i_payload),
      .i_ctrl       (i_ctrl),
      .i_stall      (i_stall),
      .i_flush      (i_flush),
      .o_ready      (o_ready),
      .o_valid      (o_valid),
      .o_payload    (o_payload),
      .o_ctrl       (o_ctrl)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .o_stall_cnt  (o_stall_cnt),
      .o_bubble_cnt (o_bubble_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Expected output stream (payload,ctrl) in capture order.
   logic [PW+CW-1:0] sb [$];
   // Slot positions of in-flight instructions, oldest (closest to output) first.
   int               mpos [$];
   logic [31:0]      sc = '0;
   logic [31:0]      bc = '0;
   bit               check_rst_pay = 1'b0;

   task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic bit m_valid();
      return (mpos.size() > 0) && (mpos[0] == D - 1);
   endfunction

   function automatic logic [PW-1:0] rnd_pay();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [31:0] inc_sat(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   // One clock: inputs applied just after an edge, outputs checked on the
   // falling edge, reference model advanced on the next rising edge.
   task automatic step(input bit v, input logic [PW-1:0] p, input logic [CW-1:0] c,
                       input bit st, input bit fl);
      bit ready;
      bit mv;
      int lim;
      int np;
      i_valid   = v;
      i_payload = p;
      i_ctrl    = c;
      i_stall   = st;
      i_flush   = fl;
      @(negedge clk);
      mv    = m_valid();
      ready = (mpos.size() < D) || !st;
      chk("o_valid", o_valid, mv);
      chk("o_ready", o_ready, ready);
      if (!mv) chk("idle_ctrl_zero", o_ctrl, '0);
      if (check_rst_pay) begin
         chk("rst_payload", o_payload, '0);
         chk("rst_ctrl", o_ctrl, '0);
         check_rst_pay = 1'b0;
      end
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", o_stall_cnt, sc);
      chk("bubble_cnt", o_bubble_cnt, bc);
`endif
      @(posedge clk);
      if (mv && st) sc = inc_sat(sc);
      if (!mv)      bc = inc_sat(bc);
      if (fl) begin
         mpos.delete();
         sb.delete();
      end else begin
         if (!st && mv) void'(mpos.pop_front());
         lim = D;
         foreach (mpos[i]) begin
            np      = (mpos[i] + 1 < lim) ? mpos[i] + 1 : lim - 1;
            mpos[i] = np;
            lim     = np;
         end
         if (ready && v) begin
            mpos.push_back(0);
            sb.push_back({p, c});
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, rnd_pay(), CW'($urandom), 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      i_valid   = 1'b1;
      i_payload = rnd_pay();
      i_ctrl    = CW'($urandom);
      i_stall   = 1'b0;
      i_flush   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mpos.delete();
      sb.delete();
      sc = '0;
      bc = '0;
      rst = 1'b0;
      check_rst_pay = 1'b1;
   endtask

   // Output monitor: every consumed valid output must be the next expected item.
   always @(negedge clk) begin
      logic [PW+CW-1:0] it;
      if (!rst && o_valid === 1'b1 && !i_stall && !i_flush) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got output %h with no expected item", o_payload);
         end else begin
            it = sb.pop_front();
            chk("out_payload", o_payload, it[PW+CW-1:CW]);
            chk("out_ctrl", o_ctrl, PW'(it[CW-1:0]));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int guard;

      do_reset();
      idle(1);

      // single instruction with a known control vector
      step(1'b1, rnd_pay(), 16'h00A5, 1'b0, 1'b0);
      idle(D + 1);

      // streaming 1..8 back to back
      for (int k = 1; k <= 8; k++) step(1'b1, PW'(k), CW'($urandom), 1'b0, 1'b0);
      idle(D + 1);

      // squeeze: A, bubble (ctrl all ones), B, then stall with more input
      step(1'b1, PW'(160'hA), 16'h1111, 1'b0, 1'b0);
      step(1'b0, PW'(160'hBAD), 16'hFFFF, 1'b0, 1'b0);
      step(1'b1, PW'(160'hB), 16'h2222, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, PW'(160'hC0 + k), 16'h3333, 1'b1, 1'b0);
      idle(D + 2);

      // flush together with stall and valid input on a full pipe
      for (int k = 0; k < D; k++) step(1'b1, rnd_pay(), CW'($urandom), 1'b0, 1'b0);
      step(1'b1, rnd_pay(), 16'hFFFF, 1'b1, 1'b0);
      step(1'b1, rnd_pay(), 16'hFFFF, 1'b1, 1'b1);
      idle(D + 1);

`ifdef PIPE_STAGE_PERF_EN
      do_reset();
      idle(1);
      for (int k = 0; k < D; k++) step(1'b1, rnd_pay(), CW'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, rnd_pay(), CW'($urandom), 1'b1, 1'b0);
      step(1'b0, rnd_pay(), '0, 1'b0, 1'b1);
      idle(3);
      for (int k = 0; k < D; k++) step(1'b1, rnd_pay(), CW'($urandom), 1'b0, 1'b0);
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      sc = 32'hFFFF_FFFE;
      for (int k = 0; k < 3; k++) step(1'b0, rnd_pay(), CW'($urandom), 1'b1, 1'b0);
      idle(D + 1);
`endif

      // randomized traffic
      for (int k = 0; k < 500; k++) begin
         step($urandom_range(0, 9) < 7, rnd_pay(), CW'($urandom),
              $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3);
      end

      guard = 0;
      while (mpos.size() > 0 && guard < 20) begin
         idle(1);
         guard++;
      end
      idle(1);
      chk("drain_sb_empty", PW'(sb.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
